// File: rtl/hc194_serial_seq_if.sv
// hc194_serial_seq_if: word-in / bit-out handshakes plus the pins shared with the S_74HC194.
interface hc194_serial_seq_if #(parameter int NIBBLES = 2);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NIBBLES-1:0]   in_data;
    logic                   in_lsb;
    logic                   abort;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   bit_ready;
    logic                   done;
    logic [1:0]             hc_s;
    logic [3:0]             hc_d;
    logic                   hc_ds;
    logic                   hc_cr_n;
    logic [3:0]             hc_q;
    modport master (
        output in_valid, in_data, in_lsb, abort, bit_ready, hc_q,
        input  in_ready, bit_out, bit_valid, done, hc_s, hc_d, hc_ds, hc_cr_n
    );
    modport slave (
        input  in_valid, in_data, in_lsb, abort, bit_ready, hc_q,
        output in_ready, bit_out, bit_valid, done, hc_s, hc_d, hc_ds, hc_cr_n
    );
endinterface

// File: rtl/hc194_serial_seq.sv
// hc194_serial_seq: loads nibbles of a word into a 74HC194 and streams its edge bit out.
module hc194_serial_seq #(parameter int NIBBLES = 2) (
    input logic              CP,
    input logic              CR_n,
    hc194_serial_seq_if.slave bus
);
    localparam int NW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [NW-1:0] LAST = NW'(NIBBLES - 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t                 state, state_nxt;
    logic [NIBBLES-1:0][3:0] word;
    logic                   lsb_q, done_q, done_nxt, accept;
    logic [1:0]             bit_cnt, bit_nxt;
    logic [NW-1:0]          nib_idx, nib_nxt, sel, pos;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = state == IDLE && !bus.abort;
    assign bus.bit_valid = state == SHIFT;
    assign bus.bit_out   = lsb_q ? bus.hc_q[0] : bus.hc_q[3];
    assign bus.done      = done_q;
    assign bus.hc_ds     = 1'b0;
    // nibble to present on hc_d: first one in LOAD, the following one on an overlapped load
    assign sel = state == LOAD ? '0 : nib_idx + 1'b1;
    assign pos = lsb_q ? sel : LAST - sel;
    always_comb begin
        state_nxt   = state;
        bit_nxt     = bit_cnt;
        nib_nxt     = nib_idx;
        done_nxt    = 1'b0;
        bus.hc_s    = 2'b00;
        bus.hc_d    = 4'h0;
        bus.hc_cr_n = 1'b1;
        if (bus.abort) begin
            bus.hc_cr_n = 1'b0;
            state_nxt   = IDLE;
            bit_nxt     = '0;
            nib_nxt     = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state_nxt = LOAD;
                    nib_nxt   = '0;
                end
                LOAD: begin
                    bus.hc_s  = 2'b11;
                    bus.hc_d  = word[pos];
                    state_nxt = SHIFT;
                    bit_nxt   = '0;
                end
                SHIFT: if (bus.bit_ready) begin
                    if (bit_cnt != 2'd3) begin
                        bus.hc_s = lsb_q ? 2'b01 : 2'b10;
                        bit_nxt  = bit_cnt + 1'b1;
                    end else if (nib_idx != LAST) begin
                        bus.hc_s = 2'b11;
                        bus.hc_d = word[pos];
                        nib_nxt  = nib_idx + 1'b1;
                        bit_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        bit_nxt   = '0;
                        nib_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge CP or negedge CR_n) begin
        if (!CR_n) begin
            state   <= IDLE;
            word    <= '0;
            lsb_q   <= 1'b0;
            bit_cnt <= '0;
            nib_idx <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            nib_idx <= nib_nxt;
            done_q  <= done_nxt;
            if (accept) begin
                word  <= bus.in_data;
                lsb_q <= bus.in_lsb;
            end
        end
    end
endmodule

// File: tb/tb_hc194_serial_seq.sv
// tb_hc194_serial_seq: drives the sequencer against a behavioural 74HC194 in the loop.
module tb_hc194_serial_seq;
    logic       CP = 1'b0;
    logic       CR_n = 1'b0;
    logic [3:0] q = 4'h0;
    int         total = 0;
    int         bad = 0;
    hc194_serial_seq_if #(.NIBBLES(2)) bus();
    hc194_serial_seq #(.NIBBLES(2)) dut (.CP(CP), .CR_n(CR_n), .bus(bus));
    always #5 CP = ~CP;
    assign bus.hc_q = q;
    // 74HC194: sync clear, 01 moves toward Q[0], 10 moves toward Q[3], DS fills the vacated end
    always @(posedge CP) begin
        if (!bus.hc_cr_n) q <= 4'h0;
        else begin
            case (bus.hc_s)
                2'b01:   q <= {bus.hc_ds, q[3:1]};
                2'b10:   q <= {q[2:0], bus.hc_ds};
                2'b11:   q <= bus.hc_d;
                default: q <= q;
            endcase
        end
    end
    typedef struct {
        logic [7:0] data;
        logic       lsb;
        logic [7:0] bits;
        logic [3:0] first_d;
        int         stall_at;
        int         stall_len;
    } vec_t;
    vec_t vecs[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [31:0] exp_hs(input logic lsb, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++)
            r[2*i +: 2] = (i % 8 == 3) ? 2'b11 : (i % 8 == 7) ? 2'b00 : (lsb ? 2'b01 : 2'b10);
        return r;
    endfunction
    task automatic collect(input int n, input logic [15:0] exp, input int stall_at, input int stall_len,
                           output logic [15:0] bits, output logic [31:0] hs, output int done_cnt,
                           output int acc_done);
        int   got = 0;
        int   cyc = 0;
        int   st = 0;
        logic drop = 1'b0;
        bits = '0;
        hs = '0;
        done_cnt = 0;
        acc_done = 0;
        while (got < n && cyc < 100) begin
            @(negedge CP);
            cyc++;
            if (drop) begin
                bus.in_valid = 1'b0;
                drop = 1'b0;
            end
            bus.bit_ready = !(got == stall_at && st < stall_len);
            #1;
            if (cyc == 1) chk("first_bit_latency", bus.bit_valid, 1'b1);
            if (bus.done) begin
                done_cnt++;
                if (bus.in_valid && bus.in_ready) begin
                    acc_done++;
                    drop = 1'b1;
                end
            end
            if (bus.bit_valid && !bus.bit_ready) begin
                st++;
                chk("stall_hold_s", bus.hc_s, 2'b00);
                chk("stall_bit_stable", bus.bit_out, exp[got]);
            end
            if (bus.bit_valid && bus.bit_ready) begin
                bits[got] = bus.bit_out;
                hs[2*got +: 2] = bus.hc_s;
                got++;
            end
        end
        bus.bit_ready = 1'b1;
        if (got < n) chk("collect_timeout", got, n);
    endtask
    task automatic start_word(input logic [7:0] data, input logic lsb);
        @(negedge CP);
        bus.in_data = data;
        bus.in_lsb = lsb;
        bus.in_valid = 1'b1;
        bus.bit_ready = 1'b1;
        #1;
        chk("in_ready_idle", bus.in_ready, 1'b1);
        @(negedge CP);
        bus.in_valid = 1'b0;
        #1;
    endtask
    task automatic run_vec(input int i);
        logic [15:0] bits;
        logic [31:0] hs;
        int          dc, ad;
        start_word(vecs[i].data, vecs[i].lsb);
        chk("load_s", bus.hc_s, 2'b11);
        chk("load_d", bus.hc_d, vecs[i].first_d);
        chk("load_no_valid", bus.bit_valid, 1'b0);
        collect(8, {8'h00, vecs[i].bits}, vecs[i].stall_at, vecs[i].stall_len, bits, hs, dc, ad);
        chk("bits", bits, vecs[i].bits);
        chk("hc_s_seq", hs, exp_hs(vecs[i].lsb, 8));
        @(negedge CP);
        #1;
        chk("done_pulse", bus.done, 1'b1);
        chk("done_in_ready", bus.in_ready, 1'b1);
        @(negedge CP);
        #1;
        chk("done_clear", bus.done, 1'b0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    initial begin
        logic [15:0] bits;
        logic [31:0] hs;
        int          dc, ad;
        vecs[0] = '{8'h1E, 1'b1, 8'h1E, 4'hE, -1, 0};
        vecs[1] = '{8'h1E, 1'b0, 8'h78, 4'h1, -1, 0};
        vecs[2] = '{8'h1E, 1'b1, 8'h1E, 4'hE, 2, 3};
        vecs[3] = '{8'hA5, 1'b0, 8'hA5, 4'hA, -1, 0};
        vecs[4] = '{8'h3C, 1'b1, 8'h3C, 4'hC, 3, 2};
        vecs[5] = '{8'h96, 1'b0, 8'h69, 4'h9, 5, 1};
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_lsb = 1'b0;
        bus.abort = 1'b0;
        bus.bit_ready = 1'b0;
        #3;
        chk("rst_valid", bus.bit_valid, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_s", bus.hc_s, 2'b00);
        chk("rst_d", bus.hc_d, 4'h0);
        chk("rst_ds", bus.hc_ds, 1'b0);
        chk("rst_cr", bus.hc_cr_n, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        @(negedge CP);
        CR_n = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(i);
        // abort after five bits: 194 cleared, no done, next word intact
        start_word(8'h1E, 1'b1);
        collect(5, 16'h001E, -1, 0, bits, hs, dc, ad);
        chk("abort_prefix", bits, 16'h001E);
        @(negedge CP);
        bus.abort = 1'b1;
        #1;
        chk("abort_cr", bus.hc_cr_n, 1'b0);
        chk("abort_s", bus.hc_s, 2'b00);
        @(negedge CP);
        bus.abort = 1'b0;
        #1;
        chk("abort_idle_ready", bus.in_ready, 1'b1);
        chk("abort_no_valid", bus.bit_valid, 1'b0);
        chk("abort_no_done", bus.done, 1'b0);
        chk("abort_q_cleared", q, 4'h0);
        @(negedge CP);
        #1;
        chk("abort_no_done_late", bus.done, 1'b0);
        run_vec(1);
        // back-to-back: second word accepted in the done cycle
        @(negedge CP);
        bus.in_data = 8'h1E;
        bus.in_lsb = 1'b1;
        bus.in_valid = 1'b1;
        bus.bit_ready = 1'b1;
        @(negedge CP);
        bus.in_data = 8'hC3;
        #1;
        chk("b2b_busy", bus.in_ready, 1'b0);
        collect(16, 16'hC31E, -1, 0, bits, hs, dc, ad);
        chk("b2b_bits", bits, 16'hC31E);
        chk("b2b_hc_s_seq", hs, exp_hs(1'b1, 16));
        chk("b2b_done_cnt", dc, 1);
        chk("b2b_accept_in_done", ad, 1);
        @(negedge CP);
        #1;
        chk("b2b_done2", bus.done, 1'b1);
        // async reset in the middle of a word
        start_word(8'hA5, 1'b1);
        collect(3, 16'h00A5, -1, 0, bits, hs, dc, ad);
        @(posedge CP);
        #3;
        CR_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.bit_valid, 1'b0);
        chk("mid_rst_s", bus.hc_s, 2'b00);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_cr", bus.hc_cr_n, 1'b1);
        @(negedge CP);
        CR_n = 1'b1;
        run_vec(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
